// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the segmented pipelined adder: operation encodings and
// the stage-count derivation reused by the multiplier top.
package pipe_adder_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  function automatic int num_stages(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/pipe_adder_seg_adder.sv
// SEG-bit ripple adder built from full_adder cells; also exposes the carry into
// its top bit so the final stage can derive signed overflow.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module seg_adder import pipe_adder_pkg::*; #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout,
  output logic           c_msb_in
);
  logic [SEG:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SEG; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  assign cout     = c[SEG];
  assign c_msb_in = c[SEG-1];
endmodule

// File: rtl/pipe_adder.sv
// Pipelined two's-complement adder/subtractor: one SEG-bit segment resolved per
// stage with the carry registered between stages, valid/ready on both sides.
module pipe_adder import pipe_adder_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  if ((SEG < 1) || (SEG > WIDTH) || ((WIDTH % SEG) != 0)) begin : g_param_check
    $error("pipe_adder: WIDTH must be a positive multiple of SEG");
  end

  localparam int NUM_STAGES = num_stages(WIDTH, SEG);
  localparam int LAST       = NUM_STAGES - 1;

  logic [NUM_STAGES-1:0] vld_p;
  logic [NUM_STAGES-1:0] adv;
  logic [NUM_STAGES-1:0] load;
  logic [WIDTH-1:0]      sum_p   [NUM_STAGES];
  logic [WIDTH-1:0]      a_p     [NUM_STAGES];
  logic [WIDTH-1:0]      b_p     [NUM_STAGES];
  logic                  carry_p [NUM_STAGES];
  logic                  cmsb_w  [NUM_STAGES];
  logic                  cmsb_p;

  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // Subtraction is folded into B and the carry at acceptance.
  assign b_eff  = (sub == MODE_SUB) ? ~b : b;
  assign c_eff  = (sub == MODE_SUB) ? 1'b1 : cin;
  assign accept = in_valid & in_ready;

  // A stage may move on if the output takes a result or any later stage has a hole.
  always_comb begin
    logic space;
    adv   = '0;
    space = out_ready;
    for (int k = LAST; k >= 0; k--) begin
      adv[k] = vld_p[k] & space;
      space  = space | ~vld_p[k];
    end
  end

  assign in_ready = rst_n & (~vld_p[0] | adv[0]);

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_src;
    logic [WIDTH-1:0] b_src;
    logic [WIDTH-1:0] sum_base;
    logic [WIDTH-1:0] sum_nx;
    logic [SEG-1:0]   seg_s;
    logic             seg_ci;
    logic             seg_co;

    if (k == 0) begin : g_head
      assign a_src    = a;
      assign b_src    = b_eff;
      assign sum_base = '0;
      assign seg_ci   = c_eff;
      assign load[k]  = accept;
    end else begin : g_body
      assign a_src    = a_p[k-1];
      assign b_src    = b_p[k-1];
      assign sum_base = sum_p[k-1];
      assign seg_ci   = carry_p[k-1];
      assign load[k]  = adv[k-1];
    end

    seg_adder #(.SEG(SEG)) u_seg (
      .a        (a_src[SEG-1:0]),
      .b        (b_src[SEG-1:0]),
      .cin      (seg_ci),
      .s        (seg_s),
      .cout     (seg_co),
      .c_msb_in (cmsb_w[k])
    );

    always_comb begin
      sum_nx = sum_base;
      sum_nx[k*SEG +: SEG] = seg_s;
    end

    // Stage k boundary: resolved low bits, carry, and the still-unconsumed operand bits.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sum_p[k]   <= '0;
        a_p[k]     <= '0;
        b_p[k]     <= '0;
        carry_p[k] <= 1'b0;
      end else if (load[k]) begin
        sum_p[k]   <= sum_nx;
        a_p[k]     <= a_src >> SEG;
        b_p[k]     <= b_src >> SEG;
        carry_p[k] <= seg_co;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p  <= '0;
      cmsb_p <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (load[k])     vld_p[k] <= 1'b1;
        else if (adv[k]) vld_p[k] <= 1'b0;
      end
      if (load[LAST]) cmsb_p <= cmsb_w[LAST];
    end
  end

  assign out_valid = vld_p[LAST];
  assign s         = sum_p[LAST];
  assign cout      = carry_p[LAST];
  assign ovf       = cmsb_p ^ carry_p[LAST];

endmodule

// File: tb/tb_pipe_adder.sv
// Directed and scoreboard bench for pipe_adder at WIDTH=16, SEG=4.
module tb_pipe_adder;
  localparam int WIDTH      = 16;
  localparam int SEG        = 4;
  localparam int NUM_STAGES = WIDTH / SEG;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
  );

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Independent reference: plain wide addition, overflow from operand/result signs.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mc, input logic ms);
    logic [15:0] be;
    logic        ce;
    logic [16:0] r;
    logic        ov;
    be = ms ? ~mb : mb;
    ce = ms ? 1'b1 : mc;
    r  = {1'b0, ma} + {1'b0, be} + {16'b0, ce};
    ov = (ma[15] == be[15]) && (r[15] != ma[15]);
    return {r[15:0], r[16], ov};
  endfunction

  logic [17:0] q[$];
  logic        mon_en     = 1'b0;
  logic        mark_first = 1'b0;
  int          cyc        = 0;
  int          emit_cnt   = 0;
  int          acc_cnt    = 0;
  int          first_emit = 0;
  int          last_emit  = 0;

  // Scoreboard monitor: at the falling edge the values that the next rising edge transfers are stable.
  initial begin
    logic [17:0] exp_r;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        q.delete();
      end else if (mon_en) begin
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result actual=%0h required=none", s);
          end else begin
            exp_r = q.pop_front();
            check("stream_result", 32'({s, cout, ovf}), 32'(exp_r));
          end
          if (mark_first) begin
            first_emit = cyc;
            mark_first = 1'b0;
          end
          last_emit = cyc;
          emit_cnt++;
        end
        if (in_valid && in_ready) begin
          q.push_back(model(a, b, cin, sub));
          acc_cnt++;
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int n;
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
    #1;
    check({v.name, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    check({v.name, "_latency"}, 32'(n), 32'(NUM_STAGES));
    check({v.name, "_s"}, 32'(s), 32'(v.s));
    check({v.name, "_cout_ovf"}, 32'({cout, ovf}), 32'({v.cout, v.ovf}));
    @(posedge clk); #1;
    check({v.name, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  task automatic wait_emits(input int target);
    int n;
    n = 0;
    while (emit_cnt < target && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    vec_t vecs[9];
    vec_t post;
    int   e0;
    int   a0;
    logic [15:0] s_hold;
    logic        stable;

    vecs[0] = '{"add_carry8",  16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1] = '{"sub_neg",     16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[2] = '{"sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[3] = '{"full_chain",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[4] = '{"add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{"sub_cin_ign", 16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{"add_cin",     16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    vecs[7] = '{"neg_ovf",     16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[8] = '{"sub_pos",     16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0};
    post    = '{"post_reset",  16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    check("rst_cout_ovf", 32'({cout, ovf}), 32'd0);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Streaming: 8 back-to-back transactions, results must come out on 8 consecutive cycles.
    mon_en = 1'b1; mark_first = 1'b1;
    e0 = emit_cnt; a0 = acc_cnt;
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_emits(e0 + 8);
    repeat (2) @(posedge clk);
    #1;
    check("stream_accepts", 32'(acc_cnt - a0), 32'd8);
    check("stream_emits", 32'(emit_cnt - e0), 32'd8);
    check("stream_consecutive", 32'(last_emit - first_emit), 32'd7);
    check("stream_queue_empty", 32'(q.size()), 32'd0);

    // Backpressure: two results out, then stall the consumer and fill the pipe.
    e0 = emit_cnt;
    for (int i = 0; i < 2; i++) begin
      a = 16'(16'h0101 * (i + 1)); b = 16'h0002; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_emits(e0 + 2);
    check("bp_first_two", 32'(emit_cnt - e0), 32'd2);
    out_ready = 1'b0;
    a0 = acc_cnt;
    for (int i = 0; i < 10; i++) begin
      a = 16'(16'h1111 * (i + 1)); b = 16'(i); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    check("bp_accepted", 32'(acc_cnt - a0), 32'd4);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_stall_s", 32'(s), 32'h1111);
    s_hold = s;
    stable = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (s !== s_hold || out_valid !== 1'b1) stable = 1'b0;
    end
    check("bp_s_stable", 32'(stable), 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("bp_full_in_ready", 32'(in_ready), 32'd1);
    wait_emits(e0 + 6);
    repeat (4) @(posedge clk);
    #1;
    check("bp_drained", 32'(emit_cnt - e0), 32'd6);
    check("bp_queue_empty", 32'(q.size()), 32'd0);

    // Reset with three transactions in flight: none may emerge afterwards.
    e0 = emit_cnt;
    for (int i = 0; i < 3; i++) begin
      a = 16'(16'h0F00 + i); b = 16'h0011; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk); #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_s", 32'(s), 32'd0);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("midrst_none_emerged", 32'(emit_cnt - e0), 32'd0);
    mon_en = 1'b0;
    run_vec(post);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
